// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified instruction/data memory of the multicycle MIPS
//   between the CPU (port 0) and a debug/program-loader port (port 1).
//   Accesses are serialised with a req/ack handshake. A fixed memory latency
//   of MEM_LAT cycles is inserted, so a requester stalls until it sees ack.
//
//   Arbitration: round-robin by default. If the macro
//   MEM_PORT_ARBITER_CPU_PRIORITY_EN is defined, the CPU wins every tie
//   instead, and the debug port is granted only while cpu_req is low.
//
// Ports
//   clk, reset               clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata    CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack       registered CPU read data, one-cycle ack pulse
//   dbg_req/we/addr/wdata    debug-port request, held until dbg_ack
//   dbg_rdata, dbg_ack       registered debug read data, one-cycle ack pulse
//   mem_addr/we/wdata        memory request (mem_we is high for one cycle only)
//   mem_rdata                memory read data, valid MEM_LAT cycles after address
//   owner                    current/last granted port (0 = CPU, 1 = debug)
//   busy                     high in every state except IDLE
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1    // legal range 1..15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic       last_served;  // port served most recently; 1 after reset so CPU wins the first tie
  logic [3:0] cnt;
  logic       grant_dbg;

  // Grant decision, only consumed when a request is seen in IDLE.
  always_comb begin
    grant_dbg = 1'b0;
`ifdef MEM_PORT_ARBITER_CPU_PRIORITY_EN
    if (dbg_req && !cpu_req) begin
      grant_dbg = 1'b1;
    end else begin
      grant_dbg = 1'b0;
    end
`else
    // On contention the port that was not served last wins.
    if (dbg_req && (!cpu_req || !last_served)) begin
      grant_dbg = 1'b1;
    end else begin
      grant_dbg = 1'b0;
    end
`endif
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      cnt         <= 4'd0;
      owner       <= 1'b0;
      busy        <= 1'b0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          mem_we  <= 1'b0;
          if (cpu_req || dbg_req) begin
            // Latch the winner's request; requesters keep inputs stable
            // until ack, so these registers mirror the owner's inputs.
            owner     <= grant_dbg;
            cnt       <= LAT_LOAD;
            mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            mem_we    <= grant_dbg ? dbg_we    : cpu_we;
            busy      <= 1'b1;
            state     <= ACCESS;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ACCESS: begin
          // Write strobe lasts only for the first ACCESS cycle.
          mem_we <= 1'b0;
          if (cnt == 4'd0) begin
            if (owner) begin
              dbg_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
            last_served <= owner;
            cpu_ack     <= ~owner;
            dbg_ack     <= owner;
            state       <= DONE;
          end else begin
            cnt   <= cnt - 4'd1;
            state <= ACCESS;
          end
        end
        DONE: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
